// File: rtl/pe_overlay_pkg.sv
// Shared definitions for overlay processing-element slots.
//   DEFAULT_DATA_WIDTH : default per-channel payload width
//   CH_*               : directional channel indices
//   clog2()            : constant ceiling-log2 for parameter derivation
package pe_overlay_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 130;

   localparam int unsigned CH_EAST  = 0;
   localparam int unsigned CH_WEST  = 1;
   localparam int unsigned CH_NORTH = 2;
   localparam int unsigned CH_SOUTH = 3;

   // Smallest r with 2**r >= v.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pe_chan_fifo.sv
// Single-channel elastic FIFO, first-word-fall-through.
//   clk, reset          : clock, async active-high reset
//   ap_start            : global enable, low freezes the channel
//   flush               : synchronous clear of pointers and count
//   in_data/valid/ready : upstream handshake
//   out_data/valid/ready: downstream handshake
//   count               : current entry count (registered)
module pe_chan_fifo
   import pe_overlay_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int unsigned DEPTH      = 4,
   localparam int unsigned ADDR_BITS  = clog2(DEPTH),
   localparam int unsigned CW         = ADDR_BITS + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ap_start,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         count
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_BITS-1:0]  wr_ptr;
   logic [ADDR_BITS-1:0]  rd_ptr;
   logic                  push;
   logic                  pop;
   logic                  enable;

   // Reset gating keeps both strobes low while reset is held, not just after.
   assign enable    = ~reset & ap_start & ~flush;
   assign in_ready  = enable & (count != CW'(DEPTH));
   assign out_valid = enable & (count != '0);
   assign out_data  = (count != '0) ? mem[rd_ptr] : '0;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2**n.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_BITS'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/pe_passthru_fifo.sv
// Pass-through PE slot: NUM_CH independent elastic FIFO channels.
//   clk, reset            : clock, async active-high reset
//   ap_start              : global enable
//   flush[NUM_CH]         : per-channel synchronous clear
//   in_data/valid/ready   : flat upstream vectors, channel i at [i*W +: W]
//   out_data/valid/ready  : flat downstream vectors
//   occupancy             : per-channel count, ADDR_BITS+1 bits each
module pe_passthru_fifo
   import pe_overlay_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int unsigned NUM_CH     = 4,
   parameter  int unsigned DEPTH      = 4,
   localparam int unsigned ADDR_BITS  = clog2(DEPTH),
   localparam int unsigned CW         = ADDR_BITS + 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ap_start,
   input  logic [NUM_CH-1:0]            flush,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]            out_valid,
   input  logic [NUM_CH-1:0]            out_ready,
   output logic [NUM_CH*CW-1:0]         occupancy
);

   // One FIFO per channel, sliced out of the flat vectors.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pe_chan_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .ap_start  (ap_start),
         .flush     (flush[i]),
         .in_data   (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .in_valid  (in_valid[i]),
         .in_ready  (in_ready[i]),
         .out_data  (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .out_valid (out_valid[i]),
         .out_ready (out_ready[i]),
         .count     (occupancy[i*CW +: CW])
      );
   end

endmodule

// File: tb/tb_pe_passthru_fifo.sv
module tb_pe_passthru_fifo;
   import pe_overlay_pkg::*;

   localparam int unsigned DW  = 130;
   localparam int unsigned NCH = 4;
   localparam int unsigned DEP = 4;
   localparam int unsigned CW  = 3;

   logic              clk;
   logic              reset;
   logic              ap_start;
   logic [NCH-1:0]    flush;
   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [NCH*DW-1:0] out_data;
   logic [NCH-1:0]    out_valid;
   logic [NCH-1:0]    out_ready;
   logic [NCH*CW-1:0] occupancy;

   int total;
   int passed;

   pe_passthru_fifo #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP)) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      logic [2:0] e_occ;
   } vec_t;

   vec_t fill_tab [10];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [7:0] v);
      in_data[ch*DW +: DW] = DW'(v);
   endtask

   function automatic logic [DW-1:0] od(input int ch);
      return out_data[ch*DW +: DW];
   endfunction

   function automatic logic [CW-1:0] occ(input int ch);
      return occupancy[ch*CW +: CW];
   endfunction

   logic [7:0] q [$];
   int         rp [5];
   logic       e_ir, e_ov;

   initial begin
      total = 0; passed = 0;
      //              iv  d      ordy ir   ov   od     occ
      fill_tab[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
      fill_tab[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1};
      fill_tab[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2};
      fill_tab[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3};
      fill_tab[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4};
      fill_tab[5] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h11, 3'd4};
      fill_tab[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3};
      fill_tab[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2};
      fill_tab[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1};
      fill_tab[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
      rp = '{1, 0, 1, 1, 0};

      // Reset / idle
      reset = 1'b1; ap_start = 1'b1; flush = '0; in_data = '0;
      in_valid = 4'hF; out_ready = '0;
      tick(); tick();
      chk("rst_in_ready",  DW'(in_ready), '0);
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_out_data",  DW'(out_data != '0), '0);
      chk("rst_occupancy", DW'(occupancy), '0);
      in_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("post_rst_in_ready", DW'(in_ready), DW'(4'hF));

      // Fill / full / drain on east channel
      for (int r = 0; r < 10; r++) begin
         in_valid  = {3'b000, fill_tab[r].iv};
         out_ready = {3'b000, fill_tab[r].ordy};
         set_data(CH_EAST, fill_tab[r].d);
         #1;
         chk($sformatf("fill%0d_ir", r),  DW'(in_ready[CH_EAST]),  DW'(fill_tab[r].e_ir));
         chk($sformatf("fill%0d_ov", r),  DW'(out_valid[CH_EAST]), DW'(fill_tab[r].e_ov));
         chk($sformatf("fill%0d_od", r),  od(CH_EAST),             DW'(fill_tab[r].e_od));
         chk($sformatf("fill%0d_occ", r), DW'(occ(CH_EAST)),       DW'(fill_tab[r].e_occ));
         tick();
      end
      in_valid = '0; out_ready = '0;

      // Streaming on west channel: 100 words, one cycle latency, no bubbles
      for (int k = 0; k <= 100; k++) begin
         in_valid  = (k < 100) ? 4'b0010 : 4'b0000;
         out_ready = 4'b0010;
         set_data(CH_WEST, 8'(k));
         #1;
         if (k == 0) begin
            chk("stream0_ov", DW'(out_valid[CH_WEST]), '0);
         end else begin
            chk($sformatf("stream%0d_ov", k),  DW'(out_valid[CH_WEST]), DW'(1));
            chk($sformatf("stream%0d_od", k),  od(CH_WEST), DW'(k - 1));
            chk($sformatf("stream%0d_occ", k), DW'(occ(CH_WEST)), DW'(1));
         end
         tick();
      end
      in_valid = '0; out_ready = '0;
      #1;
      chk("stream_end_ov",  DW'(out_valid[CH_WEST]), '0);
      chk("stream_end_occ", DW'(occ(CH_WEST)), '0);

      // Wrap-around on north channel with irregular ready, then drain
      q.delete();
      for (int k = 0; k < 18; k++) begin
         if (k >= 10 && q.size() == 0) break;
         in_valid  = (k < 10) ? 4'b0100 : 4'b0000;
         out_ready = (k >= 10 || rp[k % 5] == 1) ? 4'b0100 : 4'b0000;
         set_data(CH_NORTH, 8'hA0 + 8'(k));
         #1;
         e_ir = (q.size() != DEP);
         e_ov = (q.size() != 0);
         chk($sformatf("wrap%0d_ir", k),  DW'(in_ready[CH_NORTH]),  DW'(e_ir));
         chk($sformatf("wrap%0d_ov", k),  DW'(out_valid[CH_NORTH]), DW'(e_ov));
         chk($sformatf("wrap%0d_occ", k), DW'(occ(CH_NORTH)),       DW'(q.size()));
         if (e_ov) chk($sformatf("wrap%0d_od", k), od(CH_NORTH), DW'(q[0]));
         tick();
         if (e_ov && out_ready[CH_NORTH]) void'(q.pop_front());
         if (e_ir && in_valid[CH_NORTH])  q.push_back(8'hA0 + 8'(k));
      end
      in_valid = '0; out_ready = '0;
      #1;
      chk("wrap_end_ov", DW'(out_valid[CH_NORTH]), '0);

      // ap_start freeze on south channel
      for (int k = 0; k < 2; k++) begin
         in_valid = 4'b1000;
         set_data(CH_SOUTH, 8'h31 + 8'(k));
         tick();
      end
      ap_start = 1'b0; in_valid = 4'b1000; out_ready = 4'b1000;
      set_data(CH_SOUTH, 8'h99);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("frz%0d_ir", k),  DW'(in_ready[CH_SOUTH]),  '0);
         chk($sformatf("frz%0d_ov", k),  DW'(out_valid[CH_SOUTH]), '0);
         chk($sformatf("frz%0d_occ", k), DW'(occ(CH_SOUTH)),       DW'(2));
         tick();
      end
      ap_start = 1'b1; in_valid = '0;
      #1;
      chk("frz_resume0_ov", DW'(out_valid[CH_SOUTH]), DW'(1));
      chk("frz_resume0_od", od(CH_SOUTH), DW'(8'h31));
      tick();
      chk("frz_resume1_od", od(CH_SOUTH), DW'(8'h32));
      tick();
      chk("frz_end_ov", DW'(out_valid[CH_SOUTH]), '0);
      out_ready = '0;

      // Flush isolation: east flushed, west untouched
      for (int k = 0; k < 3; k++) begin
         in_valid = 4'b0011;
         set_data(CH_EAST, 8'h01 + 8'(k));
         set_data(CH_WEST, 8'h11 + 8'(k));
         tick();
      end
      in_valid = '0; flush = 4'b0001;
      #1;
      chk("flush_ir0",  DW'(in_ready[CH_EAST]),  '0);
      chk("flush_ov0",  DW'(out_valid[CH_EAST]), '0);
      chk("flush_ov1",  DW'(out_valid[CH_WEST]), DW'(1));
      chk("flush_occ0", DW'(occ(CH_EAST)), DW'(3));
      tick();
      flush = '0;
      #1;
      chk("post_flush_occ0", DW'(occ(CH_EAST)), '0);
      chk("post_flush_ov0",  DW'(out_valid[CH_EAST]), '0);
      chk("post_flush_occ1", DW'(occ(CH_WEST)), DW'(3));
      out_ready = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("flush_w%0d_ov", k), DW'(out_valid[CH_WEST]), DW'(1));
         chk($sformatf("flush_w%0d_od", k), od(CH_WEST), DW'(8'h11 + 8'(k)));
         tick();
      end
      chk("flush_w_end_ov", DW'(out_valid[CH_WEST]), '0);
      out_ready = '0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
